// File: rtl/serial_par_1_8.sv
// serial_par_1_8 -- receive-side serial-to-parallel stage (32f clock domain).
//
// Shifts in one serial bit per clk_32f cycle, hunts bit-by-bit for the COM
// symbol, and locks byte alignment once SYNC_COUNT consecutive aligned COM
// bytes have been seen. While locked, every non-COM byte is presented on
// data_out with valid_out set and held for a full byte period (8 cycles) so a
// 4f-domain consumer can sample it directly. COM bytes seen while locked drop
// valid_out for that byte period and leave data_out unchanged.
//
// Parameters:
//   COM_SYMBOL  alignment / idle symbol (default 8'hBC)
//   SYNC_COUNT  consecutive aligned COM bytes required for lock (1..15)
//
// Ports:
//   clk_32f    in   bit clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   data_in    in   serial bit, one per cycle
//   data_out   out  [7:0] recovered payload byte, held 8 cycles
//   valid_out  out  data_out carries a payload (non-COM) byte
//   active     out  byte alignment locked
//   byte_stb   out  one-cycle pulse on every byte boundary while locked
//
// Build option:
//   LSB_FIRST_EN  when defined the serial order is LSB first; otherwise MSB
//                 first. Timing is identical in both builds.

module serial_par_1_8 #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_stb
);

  localparam logic [3:0] SyncCnt = 4'(SYNC_COUNT);

  typedef enum logic [1:0] {
    StSearch,
    StCount,
    StLocked
  } state_e;

  state_e     state_q;
  logic [7:0] sr_q;
  logic [7:0] sr_d;
  logic [2:0] bit_cnt_q;
  logic [3:0] com_cnt_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       active_q;
  logic       stb_q;

  logic       is_com;
  logic       last_bit;

  // Next shift-register value: all comparisons and captured data use this,
  // so a byte is recognised on the same edge that samples its last bit.
  always_comb begin
`ifdef LSB_FIRST_EN
    sr_d = {data_in, sr_q[7:1]};
`else
    sr_d = {sr_q[6:0], data_in};
`endif
  end

  assign is_com   = (sr_d == COM_SYMBOL);
  assign last_bit = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= StSearch;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_q + 3'd1;
      stb_q     <= 1'b0;

      unique case (state_q)
        StSearch: begin
          // Bit-granular hunt: a match fixes byte alignment at this bit.
          if (is_com) begin
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd1;
            if (SyncCnt == 4'd1) begin
              state_q  <= StLocked;
              active_q <= 1'b1;
            end else begin
              state_q <= StCount;
            end
          end
        end

        StCount: begin
          if (last_bit) begin
            if (is_com) begin
              if (com_cnt_q + 4'd1 == SyncCnt) begin
                state_q  <= StLocked;
                active_q <= 1'b1;
              end else begin
                com_cnt_q <= com_cnt_q + 4'd1;
              end
            end else begin
              // Broken run: drop this byte, resume hunting next cycle.
              com_cnt_q <= 4'd0;
              state_q   <= StSearch;
            end
          end
        end

        StLocked: begin
          // Lock is held until reset; there is no loss-of-lock detection.
          if (last_bit) begin
            stb_q <= 1'b1;
            if (is_com) begin
              valid_q <= 1'b0;
            end else begin
              data_q  <= sr_d;
              valid_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= StSearch;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;
  assign byte_stb  = stb_q;

endmodule
